multicycle_ctrl: RTL

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/multicycle_ctrl.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl
//   Control FSM for a multicycle processor core. Each instruction walks
//   FETCH -> DECODE -> (EXECUTE) -> (MEM) -> (WB) and returns to FETCH.
//   All strobes and mux selects are decoded from the current stage, the IR
//   opcode and (in FETCH/MEM only) mem_ready.
//
// Optional feature: define MULTICYCLE_CTRL_IRQ_EN to add the interrupt
//   input irq and the acknowledge output irq_ack. Interrupts are only
//   taken at instruction boundaries or while halted.
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   opcode[4:0]         opcode held in IR
//   status_reg          flag word (Z_BIT = equal, HE_BIT = higher-or-equal)
//   mem_ready           memory finishes the current access this cycle
//   ALU_in2_mux         0 reg2, 1 immediate, 2 compare immediate
//   mem_out_mux         store data select
//   PC_mux              0 PC+1, 1 branch target, 2 register, 3 reset, 4 irq
//   memory_addr_mux     0 PC, 2 immediate, 3 register
//   data_in_mux         0 ALU, 1 memory, 2 immediate, 3 link PC
//   mem_req             memory access request
//   *_write             register / memory write strobes
//   stage[2:0]          current FSM state
//   halted              core sits in HALT
//   irq, irq_ack        interrupt request / acknowledge (IRQ build only)
module multicycle_ctrl #(
    parameter int WORD_SIZE = 16,
    parameter int Z_BIT     = 0,
    parameter int HE_BIT    = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [4:0]           opcode,
    input  logic [WORD_SIZE-1:0] status_reg,
    input  logic                 mem_ready,
    output logic [1:0]           ALU_in2_mux,
    output logic                 mem_out_mux,
    output logic [2:0]           PC_mux,
    output logic [1:0]           memory_addr_mux,
    output logic [1:0]           data_in_mux,
    output logic                 mem_req,
    output logic                 reg_buff1_write,
    output logic                 reg_buff2_write,
    output logic                 status_reg_write,
    output logic                 ALU_out_write,
    output logic                 reg_write,
    output logic                 PC_write,
    output logic                 IR_write,
    output logic                 memory_write,
    output logic [2:0]           stage,
    output logic                 halted
`ifdef MULTICYCLE_CTRL_IRQ_EN
    ,
    input  logic                 irq,
    output logic                 irq_ack
`endif
);

    typedef enum logic [2:0] {
        FETCH   = 3'd0,
        DECODE  = 3'd1,
        EXECUTE = 3'd2,
        MEM     = 3'd3,
        WB      = 3'd4,
        RST     = 3'd5,
        HALT    = 3'd6,
        IRQ     = 3'd7
    } state_t;

    // Initializer gives the power-up state on targets that support it.
    state_t stage_q = RST;
    state_t stage_d;
    state_t eoi_state;

    logic is_rr, is_alu, is_cmp, is_branch, is_br, is_link;
    logic is_load, is_store, is_load_r, is_store_r, is_load_i;
    logic is_nop, is_halt, is_illegal;
    logic z_flag, he_flag, branch_cancel;
    logic status_unused;

    assign is_rr      = (opcode[4:3] == 2'b00);
    assign is_alu     = ~opcode[4];
    assign is_cmp     = ~opcode[4] & (opcode[2:0] == 3'b111);
    assign is_branch  = (opcode[4:3] == 2'b10);
    assign is_br      = (opcode == 5'b10000);
    assign is_link    = (opcode == 5'b10001) | (opcode == 5'b10100) | (opcode == 5'b10101);
    assign is_load    = (opcode == 5'b11000);
    assign is_store   = (opcode == 5'b11001);
    assign is_load_r  = (opcode == 5'b11010);
    assign is_store_r = (opcode == 5'b11011);
    assign is_load_i  = (opcode == 5'b11100);
    assign is_nop     = (opcode == 5'b11101);
    assign is_halt    = (opcode == 5'b11110);
    assign is_illegal = (opcode == 5'b11111);

    assign z_flag        = status_reg[Z_BIT];
    assign he_flag       = status_reg[HE_BIT];
    assign status_unused = ^status_reg;
    assign stage         = stage_q;

    always_comb begin
        branch_cancel = 1'b0;
        case (opcode)
            5'b10010, 5'b10100: branch_cancel = ~z_flag;
            5'b10011, 5'b10101: branch_cancel = z_flag;
            5'b10110:           branch_cancel = ~he_flag;
            5'b10111:           branch_cancel = he_flag;
            default:            branch_cancel = 1'b0;
        endcase
    end

    // Instruction boundary: the only point where an interrupt is accepted.
    always_comb begin
`ifdef MULTICYCLE_CTRL_IRQ_EN
        eoi_state = irq ? IRQ : FETCH;
`else
        eoi_state = FETCH;
`endif
    end

    always_comb begin
        stage_d          = stage_q;
        ALU_in2_mux      = 2'd0;
        mem_out_mux      = 1'b0;
        PC_mux           = 3'd0;
        memory_addr_mux  = 2'd0;
        data_in_mux      = 2'd0;
        mem_req          = 1'b0;
        reg_buff1_write  = 1'b0;
        reg_buff2_write  = 1'b0;
        status_reg_write = 1'b0;
        ALU_out_write    = 1'b0;
        reg_write        = 1'b0;
        PC_write         = 1'b0;
        IR_write         = 1'b0;
        memory_write     = 1'b0;
        halted           = 1'b0;
`ifdef MULTICYCLE_CTRL_IRQ_EN
        irq_ack          = 1'b0;
`endif
        case (stage_q)
            FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    IR_write = 1'b1;
                    PC_write = 1'b1;
                    stage_d  = DECODE;
                end
            end
            DECODE: begin
                reg_buff1_write = is_alu | is_br | is_store | is_load_r | is_store_r;
                reg_buff2_write = is_rr | is_store_r;
                // br and bl are never cancelled, so they fall into the taken case.
                if (is_load_i || (is_branch && !branch_cancel)) stage_d = WB;
                else if (is_branch || is_nop || is_illegal)     stage_d = eoi_state;
                else if (is_halt)                               stage_d = HALT;
                else if (is_load || is_store)                   stage_d = MEM;
                else                                            stage_d = EXECUTE;
            end
            EXECUTE: begin
                ALU_out_write    = 1'b1;
                ALU_in2_mux      = is_rr ? 2'd0 : ((opcode == 5'b01111) ? 2'd2 : 2'd1);
                status_reg_write = ~(is_load_r | is_store_r);
                if (is_cmp)                       stage_d = eoi_state;
                else if (is_load_r || is_store_r) stage_d = MEM;
                else                              stage_d = WB;
            end
            MEM: begin
                mem_req         = 1'b1;
                memory_addr_mux = (is_load || is_store) ? 2'd2 : 2'd3;
                if (is_load || is_load_r) begin
                    data_in_mux = 2'd1;
                    reg_write   = mem_ready;
                end else begin
                    mem_out_mux  = is_store;
                    memory_write = mem_ready;
                end
                if (mem_ready) stage_d = eoi_state;
            end
            WB: begin
                if (is_alu) begin
                    reg_write = 1'b1;
                end else if (is_load_i) begin
                    reg_write   = 1'b1;
                    data_in_mux = 2'd2;
                end else if (is_link) begin
                    reg_write   = 1'b1;
                    data_in_mux = 2'd3;
                end
                if (is_branch) begin
                    PC_write = 1'b1;
                    PC_mux   = is_br ? 3'd2 : 3'd1;
                end
                stage_d = eoi_state;
            end
            RST: begin
                PC_mux   = 3'd3;
                PC_write = 1'b1;
                stage_d  = FETCH;
            end
            HALT: begin
                halted = 1'b1;
`ifdef MULTICYCLE_CTRL_IRQ_EN
                if (irq) stage_d = IRQ;
`endif
            end
            IRQ: begin
                data_in_mux = 2'd3;
                reg_write   = 1'b1;
                PC_mux      = 3'd4;
                PC_write    = 1'b1;
`ifdef MULTICYCLE_CTRL_IRQ_EN
                irq_ack     = 1'b1;
`endif
                stage_d     = FETCH;
            end
            default: stage_d = RST;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) stage_q <= RST;
        else       stage_q <= stage_d;
    end

endmodule
